motion_system_mc: RTL and testbench
===================================

// Module: motion_system_mc
// PURPOSE
//  Parametrised multi-axis successor to the motion top level: NUM_CHANNELS axes, each with a
//  4x quadrature position counter and a PWM generator, behind one strobe/ack register bus.
//  Replaces the hard-wired two-channel structure with a shared register bus and a decoded,
//  registered readback path. Sits directly under the FPGA top, between host bus logic and pins.
// PARAMETERS
//  NUM_CHANNELS  4    number of axes, 1..60 (NUM_CHANNELS*4 <= 8'hF0)
//  PWM_W         16   width of PWM period/on-time registers and counter
//  PRESCALE      50   CLOCK_50 cycles per PWM tick (>=1); 50 gives a 1 MHz tick
// PORTS
//  CLOCK_50     in   1               system clock, all logic on rising edge
//  reset        in   1               synchronous, active-high
//  reg_address  in   8               register address
//  reg_wdata    in   32              write data
//  reg_write    in   1               write strobe, one cycle
//  reg_read     in   1               read strobe, one cycle
//  reg_rdata    out  32              read data, valid while reg_ack=1, held afterwards
//  reg_ack      out  1               one-cycle acknowledge
//  quad_A/B/I   in   NUM_CHANNELS    asynchronous encoder inputs, one bit per axis
//  pwm_out      out  NUM_CHANNELS    PWM outputs
//  quad_error   out  NUM_CHANNELS    sticky illegal-transition flag per axis
// BEHAVIOUR
//  Reset: pwm_out=0, reg_ack=0, reg_rdata=0, quad_error=0. All registers, counters, shadows=0.
//  Register map, axis n, base=4n: +0 CONFIG, +1 PWM_PERIOD, +2 PWM_ON, +3 QUAD_COUNT (32b signed).
//   CONFIG[0] pwm_en, [1] quad_en, [2] dir_invert, [3] index_clear; read bit8=quad_error.
//   Writing CONFIG with bit8=1 clears quad_error; other bits are written as given.
//   8'hFF ID (read-only) = {16'h4D53, 8'(NUM_CHANNELS), 8'h02}. Other addresses: writes ignored,
//   reads return 0. ack is issued in every case.
//  Bus: strobe in cycle t -> reg_ack=1 in cycle t+1 exactly, fully pipelined (back-to-back
//   strobes give back-to-back acks). Write takes effect at the t+1 edge. reg_read and reg_write
//   together: only the write is performed, rdata unchanged, single ack.
//  Quadrature: 2-FF synchroniser per input; decode from registered previous {A,B}.
//   One-bit Gray step: +/-1, direction swapped when dir_invert=1. Both bits change: no count,
//   quad_error set. Counting only while quad_en=1; synchroniser runs regardless.
//   Synced I rising edge with index_clear=1 loads 0, overriding that cycle's step.
//   Signed 32-bit wrap: 32'h7FFFFFFF +1 -> 32'h80000000.
//   Bus write to QUAD_COUNT in the same cycle as a step or index clear: write wins.
//   Error set and clear in the same cycle: set wins.
//  PWM: shared prescaler emits one-cycle tick every PRESCALE clocks. Per axis, the counter
//   steps 0..period-1 on each tick. pwm_out = pwm_en & (cnt < on_shadow).
//   PWM_PERIOD/PWM_ON write to holding registers. Shadows load when the counter wraps to 0,
//   and on the first tick after pwm_en rises (counter restarts at 0).
//   period=0: output low, counter held at 0. on>=period: constant high. on=0: constant low.
//   pwm_en=0 forces pwm_out=0 within one cycle.
//  Reset mid-operation: everything returns to reset values on the next edge. An in-flight
//   strobe is dropped and gets no ack.
// STRUCTURE
//  Package types: register offsets (CONFIG/PERIOD/ON/COUNT), CONFIG bit-position constants,
//   ID constant, typedef register_t (32b), typedef config_t packed struct.
//  Sub-module motion_axis (one per channel via generate): synchroniser, quadrature decoder,
//   counter, PWM counter and shadows. Registered read port.
//  Top level holds: prescaler, address decode, readback mux, ack pipeline.
// TESTING
//  1 Reset, then read 8'hFF -> ack at t+1, rdata = 32'h4D53_0402 (NUM_CHANNELS=4).
//  2 Axis 1: CONFIG=2, apply 8 forward Gray steps -> count +8. Set dir_invert, same
//    stimulus -> count back to 0. Read 8'h07 confirms.
//  3 Toggle A and B together -> count unchanged, quad_error[0]=1. CONFIG write 32'h102 ->
//    flag clears next cycle.
//  4 Axis 0: PERIOD=10, ON=3, pwm_en=1, PRESCALE=2 -> high 6 clk, low 14 clk. Write ON=7
//    mid-period -> new duty only from next wrap.
//  5 Edge values: ON=12 with PERIOD=10 -> constant high. PERIOD=0 -> constant low.
//    Write QUAD_COUNT=32'h7FFFFFFF, +1 step -> 32'h80000000.
//  6 Same-cycle collisions: QUAD_COUNT write during a step -> written value holds.
//    read+write strobe -> one ack. Reset asserted the cycle after a strobe -> no ack.

Source files
------------

// File: rtl/motion_system_mc_pkg.sv
// Shared types and constants for the multi-axis motion block.
// Register offsets, CONFIG layout, ID word and Gray-code helper.
package motion_system_mc_pkg;

  typedef logic [31:0] register_t;
  typedef logic [1:0]  reg_off_t;

  localparam reg_off_t OFF_CONFIG = 2'd0;
  localparam reg_off_t OFF_PERIOD = 2'd1;
  localparam reg_off_t OFF_ON     = 2'd2;
  localparam reg_off_t OFF_COUNT  = 2'd3;

  localparam int CFG_ERR = 8;

  localparam logic [7:0]  ID_ADDR  = 8'hFF;
  localparam logic [15:0] ID_MAGIC = 16'h4D53;
  localparam logic [7:0]  ID_REV   = 8'h02;

  typedef struct packed {
    logic index_clear;
    logic dir_invert;
    logic quad_en;
    logic pwm_en;
  } config_t;

  // Position of {A,B} along the forward sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/motion_system_mc_axis.sv
// One motion axis: encoder synchroniser, quadrature counter,
// PWM counter with shadowed period/on-time, register slice.
module motion_axis
  import motion_system_mc_pkg::*;
#(
  parameter int PWM_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      tick,
  input  logic      wr_en,
  input  reg_off_t  wr_off,
  input  register_t wr_data,
  input  reg_off_t  rd_off,
  input  logic      qa,
  input  logic      qb,
  input  logic      qi,
  output register_t rd_data,
  output logic      pwm_out,
  output logic      quad_error
);

  config_t cfg_q, cfg_d;
  logic [PWM_W-1:0] per_h_q, per_h_d, on_h_q, on_h_d;
  logic [PWM_W-1:0] per_sh_q, per_sh_d, on_sh_q, on_sh_d;
  logic [PWM_W-1:0] pcnt_q, pcnt_d;
  logic start_q, start_d, pwm_q, pwm_d, err_q, err_d;
  register_t count_q, count_d;
  logic [2:0] s1_q, s2_q;
  logic [1:0] ab_q;
  logic i_q;
  logic [1:0] step;
  logic wrap;

  always_comb begin
    cfg_d    = cfg_q;
    per_h_d  = per_h_q;
    on_h_d   = on_h_q;
    per_sh_d = per_sh_q;
    on_sh_d  = on_sh_q;
    pcnt_d   = pcnt_q;
    start_d  = start_q;
    count_d  = count_q;
    err_d    = err_q;
    step = gray_idx(s2_q[2:1]) - gray_idx(ab_q);
    wrap = ({1'b0, pcnt_q} + (PWM_W+1)'(1)) >= {1'b0, per_sh_q};
    if (wr_en && wr_off == OFF_CONFIG && wr_data[CFG_ERR])
      err_d = 1'b0;
    if (cfg_q.quad_en) begin
      if (step == 2'd1)
        count_d = cfg_q.dir_invert ? count_q - 1 : count_q + 1;
      else if (step == 2'd3)
        count_d = cfg_q.dir_invert ? count_q + 1 : count_q - 1;
      else if (step == 2'd2)
        err_d = 1'b1;
    end
    if (cfg_q.index_clear && s2_q[0] && !i_q)
      count_d = '0;
    // Period 0 counts as a wrap every tick so new shadows can still load.
    if (!cfg_q.pwm_en) begin
      start_d = 1'b1;
      pcnt_d  = '0;
    end else if (tick) begin
      if (start_q || wrap) begin
        pcnt_d   = '0;
        per_sh_d = per_h_q;
        on_sh_d  = on_h_q;
        start_d  = 1'b0;
      end else begin
        pcnt_d = pcnt_q + PWM_W'(1);
      end
    end
    if (wr_en) begin
      unique case (wr_off)
        OFF_CONFIG: cfg_d   = config_t'(wr_data[3:0]);
        OFF_PERIOD: per_h_d = wr_data[PWM_W-1:0];
        OFF_ON:     on_h_d  = wr_data[PWM_W-1:0];
        OFF_COUNT:  count_d = wr_data;
        default: ;
      endcase
    end
    pwm_d = cfg_d.pwm_en & cfg_q.pwm_en & ~start_d
          & (|per_sh_d) & (pcnt_d < on_sh_d);
  end

  always_comb begin
    rd_data = '0;
    unique case (rd_off)
      OFF_CONFIG: rd_data = {23'd0, err_q, 4'd0, cfg_q};
      OFF_PERIOD: rd_data = 32'(per_h_q);
      OFF_ON:     rd_data = 32'(on_h_q);
      OFF_COUNT:  rd_data = count_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q    <= '0;
      per_h_q  <= '0;
      on_h_q   <= '0;
      per_sh_q <= '0;
      on_sh_q  <= '0;
      pcnt_q   <= '0;
      start_q  <= 1'b0;
      pwm_q    <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      ab_q     <= '0;
      i_q      <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      per_h_q  <= per_h_d;
      on_h_q   <= on_h_d;
      per_sh_q <= per_sh_d;
      on_sh_q  <= on_sh_d;
      pcnt_q   <= pcnt_d;
      start_q  <= start_d;
      pwm_q    <= pwm_d;
      err_q    <= err_d;
      count_q  <= count_d;
      s1_q     <= {qa, qb, qi};
      s2_q     <= s1_q;
      ab_q     <= s2_q[2:1];
      i_q      <= s2_q[0];
    end
  end

  assign pwm_out    = pwm_q;
  assign quad_error = err_q;

endmodule

// File: rtl/motion_system_mc.sv
// Multi-axis motion top: shared prescaler, register decode,
// registered readback and one-cycle ack pipeline.
module motion_system_mc
  import motion_system_mc_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PWM_W        = 16,
  parameter int PRESCALE     = 50
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [7:0]              reg_address,
  input  logic [31:0]             reg_wdata,
  input  logic                    reg_write,
  input  logic                    reg_read,
  output logic [31:0]             reg_rdata,
  output logic                    reg_ack,
  input  logic [NUM_CHANNELS-1:0] quad_A,
  input  logic [NUM_CHANNELS-1:0] quad_B,
  input  logic [NUM_CHANNELS-1:0] quad_I,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic [NUM_CHANNELS-1:0] quad_error
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic tick, in_range, is_id;
  logic ack_q, ack_d;
  register_t rdata_q, rdata_d, rd_val;
  register_t axis_rd [NUM_CHANNELS];

  assign tick     = presc_q == PW'(PRESCALE - 1);
  assign in_range = reg_address < 8'(4 * NUM_CHANNELS);
  assign is_id    = reg_address == ID_ADDR;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_axis
    motion_axis #(.PWM_W(PWM_W)) u_axis (
      .clk        (CLOCK_50),
      .reset      (reset),
      .tick       (tick),
      .wr_en      (reg_write & in_range
                   & (reg_address[7:2] == 6'(g))),
      .wr_off     (reg_address[1:0]),
      .wr_data    (reg_wdata),
      .rd_off     (reg_address[1:0]),
      .qa         (quad_A[g]),
      .qb         (quad_B[g]),
      .qi         (quad_I[g]),
      .rd_data    (axis_rd[g]),
      .pwm_out    (pwm_out[g]),
      .quad_error (quad_error[g])
    );
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_id:    rd_val = {ID_MAGIC, 8'(NUM_CHANNELS), ID_REV};
      in_range: begin
        for (int i = 0; i < NUM_CHANNELS; i++)
          if (reg_address[7:2] == 6'(i)) rd_val = axis_rd[i];
      end
      default: ;
    endcase
    presc_d = tick ? '0 : presc_q + PW'(1);
    ack_d   = reg_read | reg_write;
    // A write wins over a simultaneous read; readback is held.
    rdata_d = (reg_read && !reg_write) ? rd_val : rdata_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      presc_q <= presc_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_motion_system_mc.sv
// Randomised quadrature scoreboard plus directed bus/PWM checks
// for motion_system_mc with four axes and a prescale of two.
module tb_motion_system_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  reg_address = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_write = 1'b0;
  logic        reg_read = 1'b0;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [3:0]  quad_A = '0, quad_B = '0, quad_I = '0;
  logic [3:0]  pwm_out, quad_error;

  int n_chk = 0;
  int n_fail = 0;

  int          ph [4] = '{0, 0, 0, 0};
  logic [31:0] cnt_m [4] = '{0, 0, 0, 0};
  bit          qen_m [4] = '{0, 0, 0, 0};
  bit          dinv_m [4] = '{0, 0, 0, 0};
  bit          err_m [4] = '{0, 0, 0, 0};
  logic [1:0]  gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  motion_system_mc #(
    .NUM_CHANNELS(4), .PWM_W(16), .PRESCALE(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .reg_address(reg_address), .reg_wdata(reg_wdata),
    .reg_write(reg_write), .reg_read(reg_read),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .quad_A(quad_A), .quad_B(quad_B), .quad_I(quad_I),
    .pwm_out(pwm_out), .quad_error(quad_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a,
                           input logic [31:0] d);
    reg_address = a;
    reg_wdata = d;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    check("wr_ack", 32'(reg_ack), 32'd1);
  endtask

  task automatic read_chk(input string tag,
                          input logic [7:0] a,
                          input logic [31:0] exp);
    reg_address = a;
    reg_read = 1'b1;
    tick();
    reg_read = 1'b0;
    check({tag, "_ack"}, 32'(reg_ack), 32'd1);
    check(tag, reg_rdata, exp);
  endtask

  task automatic cfg_write(input int ch, input logic [31:0] v);
    qen_m[ch] = v[1];
    dinv_m[ch] = v[2];
    if (v[8]) err_m[ch] = 1'b0;
    bus_write(8'(4 * ch), v);
  endtask

  task automatic drive_quad(input int ch);
    logic [1:0] ab;
    ab = gtab[ph[ch] & 3];
    quad_A[ch] = ab[1];
    quad_B[ch] = ab[0];
  endtask

  task automatic quad_move(input int ch, input int d);
    ph[ch] += d;
    drive_quad(ch);
    if (qen_m[ch]) begin
      if (d == 2 || d == -2) err_m[ch] = 1'b1;
      else cnt_m[ch] += 32'(dinv_m[ch] ? -d : d);
    end
    repeat (4) tick();
  endtask

  function automatic logic [31:0] err_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = err_m[i];
    return v;
  endfunction

  task automatic wait_rise();
    logic prev;
    bit found;
    found = 0;
    prev = pwm_out[0];
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (!prev && pwm_out[0]) found = 1;
      prev = pwm_out[0];
    end
    check("pwm_rise_seen", 32'(found), 32'd1);
  endtask

  task automatic run_len(input int start, output int n);
    logic lvl;
    bit done;
    lvl = pwm_out[0];
    n = start;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (pwm_out[0] == lvl) n++;
      else done = 1;
    end
  endtask

  task automatic level_for(input int cyc, output logic [31:0] hi,
                           output logic [31:0] lo);
    hi = 1;
    lo = 1;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (!pwm_out[0]) hi = 0;
      if (pwm_out[0]) lo = 0;
    end
  endtask

  initial begin
    int hi, lo, ch, r, d;
    logic [31:0] ah, al;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ack", 32'(reg_ack), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_qerr", 32'(quad_error), 32'd0);

    read_chk("id", 8'hFF, 32'h4D53_0402);
    reg_read = 1'b1;
    reg_address = 8'hFF;
    tick();
    reg_address = 8'h20;
    tick();
    check("b2b_ack", 32'(reg_ack), 32'd1);
    check("unmapped_rd", reg_rdata, 32'd0);
    reg_read = 1'b0;
    tick();
    check("ack_drop", 32'(reg_ack), 32'd0);

    cfg_write(1, 32'h2);
    for (int i = 0; i < 8; i++) quad_move(1, 1);
    read_chk("fwd8", 8'h07, cnt_m[1]);
    cfg_write(1, 32'h6);
    for (int i = 0; i < 8; i++) quad_move(1, 1);
    read_chk("inv8", 8'h07, cnt_m[1]);

    cfg_write(0, 32'h2);
    quad_move(0, 2);
    check("qerr_set", err_vec(), 32'(quad_error));
    read_chk("qerr_cnt", 8'h03, cnt_m[0]);
    cfg_write(0, 32'h102);
    check("qerr_clr", 32'(quad_error), err_vec());
    read_chk("cfg_rd", 8'h00, 32'h2);

    for (int i = 0; i < 4; i++)
      cfg_write(i, {29'd0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'b0});
    for (int i = 0; i < 60; i++) begin
      ch = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      d = (r == 0) ? 2 : (r < 5 ? 1 : -1);
      quad_move(ch, d);
    end
    check("rand_qerr", 32'(quad_error), err_vec());
    for (int i = 0; i < 4; i++)
      read_chk("rand_cnt", 8'(4 * i + 3), cnt_m[i]);

    cfg_write(2, 32'h102);
    bus_write(8'h0B, 32'h7FFF_FFFF);
    cnt_m[2] = 32'h7FFF_FFFF;
    quad_move(2, 1);
    read_chk("wrap", 8'h0B, cnt_m[2]);

    cfg_write(3, 32'hA);
    for (int i = 0; i < 3; i++) quad_move(3, 1);
    quad_I[3] = 1'b1;
    repeat (4) tick();
    cnt_m[3] = '0;
    quad_I[3] = 1'b0;
    repeat (4) tick();
    read_chk("idx_clr", 8'h0F, cnt_m[3]);

    ph[2] += 1;
    drive_quad(2);
    tick();
    tick();
    reg_address = 8'h0B;
    reg_wdata = 32'h0000_1234;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    cnt_m[2] = 32'h0000_1234;
    repeat (4) tick();
    read_chk("wr_vs_step", 8'h0B, cnt_m[2]);

    bus_write(8'h01, 32'd10);
    bus_write(8'h02, 32'd3);
    cfg_write(0, 32'h1);
    wait_rise();
    run_len(1, hi);
    run_len(1, lo);
    check("pwm_hi3", 32'(hi), 32'd6);
    check("pwm_lo3", 32'(lo), 32'd14);
    reg_address = 8'h02;
    reg_wdata = 32'd7;
    reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    run_len(2, hi);
    run_len(1, lo);
    check("pwm_hi_old", 32'(hi), 32'd6);
    check("pwm_lo_old", 32'(lo), 32'd14);
    run_len(1, hi);
    run_len(1, lo);
    check("pwm_hi7", 32'(hi), 32'd14);
    check("pwm_lo7", 32'(lo), 32'd6);

    bus_write(8'h02, 32'd12);
    repeat (60) tick();
    level_for(30, ah, al);
    check("on_ge_period", ah, 32'd1);
    bus_write(8'h01, 32'd0);
    repeat (60) tick();
    level_for(30, ah, al);
    check("period_zero", al, 32'd1);
    bus_write(8'h01, 32'd10);
    bus_write(8'h02, 32'd3);
    wait_rise();
    cfg_write(0, 32'h0);
    check("pwm_en_off", 32'(pwm_out[0]), 32'd0);

    read_chk("id2", 8'hFF, 32'h4D53_0402);
    reg_address = 8'h0D;
    reg_wdata = 32'h55;
    reg_read = 1'b1;
    reg_write = 1'b1;
    tick();
    reg_read = 1'b0;
    reg_write = 1'b0;
    check("rw_ack", 32'(reg_ack), 32'd1);
    check("rw_rdata_held", reg_rdata, 32'h4D53_0402);
    tick();
    check("rw_single_ack", 32'(reg_ack), 32'd0);
    read_chk("rw_written", 8'h0D, 32'h55);
    bus_write(8'h20, 32'hDEAD);
    read_chk("unmapped_wr", 8'h20, 32'd0);

    reg_address = 8'hFF;
    reg_read = 1'b1;
    reset = 1'b1;
    tick();
    reg_read = 1'b0;
    reset = 1'b0;
    check("rst_strobe_ack", 32'(reg_ack), 32'd0);
    check("rst_strobe_rd", reg_rdata, 32'd0);
    tick();
    check("rst_no_late_ack", 32'(reg_ack), 32'd0);
    check("rst2_qerr", 32'(quad_error), 32'd0);
    read_chk("rst_cnt", 8'h0B, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
